mc_lc_block_sequencer: RTL and testbench



---
 rtl/mc_lc_block_sequencer.sv | 168 ++++++++++++++++
 tb/tb_mc_lc_block_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_lc_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mc_lc_block_sequencer
// Purpose  : Issues the 24 4x4 block commands of a macroblock (Y0..Y15, Cb0..Cb3,
//            Cr0..Cr3). Tracks outstanding completions and pulses mb_done once
//            every block of the macroblock has completed.
// Revision : 1.0 - initial release
// ============================================================================
module mc_lc_block_sequencer #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int MBW             = 7
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           mb_start,
   input  logic [MBW-1:0] mb_x,
   input  logic [MBW-1:0] mb_y,
   output logic           mb_busy,
   output logic           mb_done,
   output logic           cmd_valid,
   input  logic           cmd_ready,
   output logic [1:0]     cmd_comp,
   output logic [3:0]     cmd_blk_idx,
   output logic           cmd_last,
   output logic [MBW-1:0] cmd_mb_x,
   output logic [MBW-1:0] cmd_mb_y,
   input  logic           rsp_valid,
   output logic           err
);

   localparam int            OW    = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OW-1:0] C_MAX = OW'(MAX_OUTSTANDING);
   localparam logic [OW-1:0] C_ONE = OW'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE_Y = 3'd1,
      S_ISSUE_C = 3'd2,
      S_DRAIN   = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t         state_q, state_d;
   logic [3:0]     blk_cnt_q, blk_cnt_d;
   logic [OW-1:0]  outst_q, outst_d;
   logic           err_q, err_d;
   logic [MBW-1:0] mbx_q, mbx_d;
   logic [MBW-1:0] mby_q, mby_d;

   logic w_issuing;
   logic w_cmd_valid;
   logic w_hs;

   // Command valid depends only on registered state, so a same-cycle response
   // cannot open a slot; the freed slot is visible from the next cycle.
   assign w_issuing   = (state_q == S_ISSUE_Y) || (state_q == S_ISSUE_C);
   assign w_cmd_valid = w_issuing && (outst_q < C_MAX);
   assign w_hs        = w_cmd_valid && cmd_ready;

   // State, counters, sticky error and latched coordinates.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         blk_cnt_q <= '0;
         outst_q   <= '0;
         err_q     <= 1'b0;
         mbx_q     <= '0;
         mby_q     <= '0;
      end else begin
         state_q   <= state_d;
         blk_cnt_q <= blk_cnt_d;
         outst_q   <= outst_d;
         err_q     <= err_d;
         mbx_q     <= mbx_d;
         mby_q     <= mby_d;
      end
   end

   // Outstanding count and error flag; a response with nothing outstanding is
   // flagged and cannot retire the command handshaking in the same cycle.
   always_comb begin
      outst_d = outst_q;
      err_d   = err_q;
      if (rsp_valid && (outst_q == '0)) begin
         err_d   = 1'b1;
         outst_d = w_hs ? C_ONE : '0;
      end else if (w_hs && !rsp_valid) begin
         outst_d = outst_q + C_ONE;
      end else if (!w_hs && rsp_valid) begin
         outst_d = outst_q - C_ONE;
      end
      if ((state_q == S_IDLE) && mb_start) begin
         err_d = 1'b0;
      end
   end

   // Next-state logic and block counter.
   always_comb begin
      state_d   = state_q;
      blk_cnt_d = blk_cnt_q;
      mbx_d     = mbx_q;
      mby_d     = mby_q;
      case (state_q)
         S_IDLE: begin
            if (mb_start) begin
               state_d   = S_ISSUE_Y;
               blk_cnt_d = '0;
               mbx_d     = mb_x;
               mby_d     = mb_y;
            end
         end
         S_ISSUE_Y: begin
            if (w_hs) begin
               if (blk_cnt_q == 4'd15) begin
                  state_d   = S_ISSUE_C;
                  blk_cnt_d = '0;
               end else begin
                  blk_cnt_d = blk_cnt_q + 4'd1;
               end
            end
         end
         S_ISSUE_C: begin
            if (w_hs) begin
               if (blk_cnt_q == 4'd7) begin
                  state_d   = S_DRAIN;
                  blk_cnt_d = '0;
               end else begin
                  blk_cnt_d = blk_cnt_q + 4'd1;
               end
            end
         end
         S_DRAIN: begin
            if (outst_d == '0) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Command fields decoded from the state and block counter.
   always_comb begin
      cmd_comp    = 2'd0;
      cmd_blk_idx = 4'd0;
      cmd_last    = 1'b0;
      if (state_q == S_ISSUE_Y) begin
         cmd_blk_idx = blk_cnt_q;
      end else if (state_q == S_ISSUE_C) begin
         cmd_comp    = blk_cnt_q[2] ? 2'd2 : 2'd1;
         cmd_blk_idx = {2'b00, blk_cnt_q[1:0]};
         cmd_last    = (blk_cnt_q == 4'd7);
      end
   end

   assign cmd_valid = w_cmd_valid;
   assign mb_busy   = (state_q != S_IDLE);
   assign mb_done   = (state_q == S_DONE);
   assign cmd_mb_x  = mbx_q;
   assign cmd_mb_y  = mby_q;
   assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_lc_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_lc_block_sequencer
// Purpose  : Randomized self-checking bench for mc_lc_block_sequencer against a
//            transaction-level model (command list, outstanding count).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_lc_block_sequencer;

   localparam int MAX = 2;
   localparam int MBW = 7;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           mb_start;
   logic [MBW-1:0] mb_x;
   logic [MBW-1:0] mb_y;
   logic           mb_busy;
   logic           mb_done;
   logic           cmd_valid;
   logic           cmd_ready;
   logic [1:0]     cmd_comp;
   logic [3:0]     cmd_blk_idx;
   logic           cmd_last;
   logic [MBW-1:0] cmd_mb_x;
   logic [MBW-1:0] cmd_mb_y;
   logic           rsp_valid;
   logic           err;

   mc_lc_block_sequencer #(.MAX_OUTSTANDING(MAX), .MBW(MBW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .mb_start   (mb_start),
      .mb_x       (mb_x),
      .mb_y       (mb_y),
      .mb_busy    (mb_busy),
      .mb_done    (mb_done),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_comp   (cmd_comp),
      .cmd_blk_idx(cmd_blk_idx),
      .cmd_last   (cmd_last),
      .cmd_mb_x   (cmd_mb_x),
      .cmd_mb_y   (cmd_mb_y),
      .rsp_valid  (rsp_valid),
      .err        (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Transaction-level model
   bit             m_active;   // macroblock accepted and not yet completed
   bit             m_done;     // completion pulse expected this cycle
   bit             m_err;
   int             m_issued;   // commands handshaken so far (0..24)
   int             m_outst;
   logic [MBW-1:0] m_x, m_y;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Command n of a macroblock: Y0..Y15, Cb0..Cb3, Cr0..Cr3
   function automatic int exp_comp(input int n);
      return (n < 16) ? 0 : (n < 20) ? 1 : 2;
   endfunction

   function automatic int exp_idx(input int n);
      return (n < 16) ? n : (n - 16) % 4;
   endfunction

   function automatic bit exp_valid();
      return m_active && (m_issued < 24) && (m_outst < MAX);
   endfunction

   task automatic model_reset();
      m_active = 0; m_done = 0; m_err = 0;
      m_issued = 0; m_outst = 0;
      m_x = '0; m_y = '0;
   endtask

   task automatic check_outputs();
      bit ev;
      ev = exp_valid();
      chk("cmd_valid", cmd_valid, ev);
      chk("mb_busy", mb_busy, m_active || m_done);
      chk("mb_done", mb_done, m_done);
      chk("err", err, m_err);
      if (ev) begin
         chk("cmd_comp", cmd_comp, exp_comp(m_issued));
         chk("cmd_blk_idx", cmd_blk_idx, exp_idx(m_issued));
         chk("cmd_last", cmd_last, m_issued == 23);
         chk("cmd_mb_x", cmd_mb_x, m_x);
         chk("cmd_mb_y", cmd_mb_y, m_y);
      end
   endtask

   // Drive one cycle of inputs (called at a negedge), advance the model, then
   // wait for the next negedge.
   task automatic step(input bit ready, input bit rsp, input bit start);
      bit ev, hs, idle, drain;
      cmd_ready = ready;
      rsp_valid = rsp;
      mb_start  = start;
      ev    = exp_valid();
      hs    = ev && ready;
      idle  = !m_active && !m_done;
      drain = m_active && (m_issued == 24);
      if (idle && start) begin
         m_active = 1; m_issued = 0;
         m_x = mb_x; m_y = mb_y; m_err = 0;
      end else begin
         if (rsp) begin
            if (m_outst == 0) m_err = 1;
            else m_outst--;
         end
         if (hs) begin
            m_outst++;
            m_issued++;
         end
         if (m_done) m_done = 0;
         else if (drain && m_outst == 0) begin
            m_active = 0;
            m_done   = 1;
         end
      end
      @(negedge clk);
   endtask

   // One macroblock. mode: 0 = response one cycle after each handshake,
   // 1 = random responses, 2 = responses only every 7th cycle.
   // abort_at >= 0 returns when that command is presented.
   task automatic run_mb(input int ready_pct, input int mode, input int abort_at);
      bit ready, rsp, prev_hs, ev;
      int cyc, hs_cnt;
      check_outputs();
      mb_x = MBW'($urandom);
      mb_y = MBW'($urandom);
      step(1'b0, 1'b0, 1'b1);
      prev_hs = 0; cyc = 0; hs_cnt = 0;
      while ((m_active || m_done) && cyc < 3000) begin
         check_outputs();
         ev = exp_valid();
         if (abort_at >= 0 && ev && m_issued == abort_at) return;
         ready = ($urandom_range(0, 99) < ready_pct);
         case (mode)
            0:       rsp = prev_hs;
            1:       rsp = (m_outst > 0) && ($urandom_range(0, 99) < 40);
            default: rsp = (m_outst > 0) && (cyc % 7 == 0);
         endcase
         // Disturb the inputs that must be ignored while busy
         mb_x = MBW'($urandom);
         mb_y = MBW'($urandom);
         if (cmd_valid && ready) hs_cnt++;
         prev_hs = ev && ready;
         step(ready, rsp, $urandom_range(0, 3) == 0);
         cyc++;
      end
      mb_start = 0; cmd_ready = 0; rsp_valid = 0;
      checks++;
      if (cyc >= 3000) begin
         errors++;
         $error("FAIL mb_timeout observed=%0d expected<3000", cyc);
      end
      chk("hs_total", hs_cnt, 24);
      check_outputs();
   endtask

   task automatic check_reset_values();
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_mb_busy", mb_busy, 0);
      chk("rst_mb_done", mb_done, 0);
      chk("rst_cmd_last", cmd_last, 0);
      chk("rst_err", err, 0);
      chk("rst_cmd_comp", cmd_comp, 0);
      chk("rst_cmd_blk_idx", cmd_blk_idx, 0);
      chk("rst_cmd_mb_x", cmd_mb_x, 0);
      chk("rst_cmd_mb_y", cmd_mb_y, 0);
   endtask

   initial begin
      reset_n = 1'b0; mb_start = 0; cmd_ready = 0; rsp_valid = 0;
      mb_x = '0; mb_y = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_values();
      reset_n = 1'b1;
      @(negedge clk);

      // Nominal, back-to-back
      run_mb(100, 0, -1);
      run_mb(100, 0, -1);
      // Backpressure with random responses
      repeat (3) run_mb(50, 1, -1);
      // Outstanding limit: responses withheld for long stretches
      run_mb(100, 2, -1);
      run_mb(60, 2, -1);

      // Spurious response in IDLE sets err; next start clears it
      check_outputs();
      step(1'b0, 1'b1, 1'b0);
      check_outputs();
      step(1'b0, 1'b0, 1'b0);
      check_outputs();
      run_mb(100, 1, -1);

      // Reset while Cb2 (command 18) is presented
      run_mb(100, 0, 18);
      #1 reset_n = 1'b0;
      cmd_ready = 0; rsp_valid = 0; mb_start = 0;
      #1 check_reset_values();
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_mb(100, 0, -1);
      run_mb(70, 1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
